// File: rtl/sop_sweep_capture_pkg.sv
// Shared definitions for the SOP truth-table sweep/capture block.
package sop_pkg;

   localparam int NUM_VEC = 32;
   localparam int IDX_W   = 5;
   localparam int CNT_W   = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sop_sweep_capture.sv
// Drives all 32 input vectors into a 5-input SOP block, captures its response
// per vector and compares it against a latched golden truth table.
module sop_sweep_capture
   import sop_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_VEC-1:0]   expected,
   input  logic                 sop_out,
   output logic                 a,
   output logic                 b,
   output logic                 c,
   output logic                 d,
   output logic                 e,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_VEC-1:0]   truth,
   output logic [CNT_W-1:0]     mismatch_cnt,
   output logic                 fail_valid,
   output logic [IDX_W-1:0]     first_fail,
   output logic                 match
);

   localparam logic [1:0]       SETTLE_LAST = 2'(SETTLE - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     r_vec;
   logic [IDX_W-1:0]     r_first_fail;
   logic [1:0]           r_settle;
   logic [NUM_VEC-1:0]   r_exp;
   logic [NUM_VEC-1:0]   r_truth;
   logic [CNT_W-1:0]     r_mis_cnt;
   logic [CNT_W-1:0]     w_mis_cnt_nxt;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_fail_valid;
   logic                 r_match;
   logic                 w_cap;
   logic                 w_last;
   logic                 w_miss;

   // Capture strobe on the last cycle of each hold, plus next-state decode.
   always_comb begin
      w_cap         = 1'b0;
      w_last        = 1'b0;
      w_miss        = 1'b0;
      w_mis_cnt_nxt = r_mis_cnt;
      w_state_nxt   = ST_IDLE;

      w_cap         = (r_state == ST_RUN) && (r_settle == SETTLE_LAST);
      w_last        = w_cap && (r_idx == LAST_IDX);
      w_miss        = w_cap && (sop_out != r_exp[r_idx]);
      w_mis_cnt_nxt = r_mis_cnt + {{(CNT_W-1){1'b0}}, w_miss};

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Sweep sequencing, capture and mismatch bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_idx        <= '0;
         r_vec        <= '0;
         r_settle     <= 2'd0;
         r_exp        <= '0;
         r_truth      <= '0;
         r_mis_cnt    <= '0;
         r_fail_valid <= 1'b0;
         r_first_fail <= '0;
         r_match      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         r_done  <= (w_state_nxt == ST_DONE);

         case (r_state)
            ST_IDLE: begin
               r_vec <= '0;
               if (start) begin
                  r_idx        <= '0;
                  r_settle     <= 2'd0;
                  r_exp        <= expected;
                  r_truth      <= '0;
                  r_mis_cnt    <= '0;
                  r_fail_valid <= 1'b0;
                  r_first_fail <= '0;
                  r_match      <= 1'b0;
               end else begin
                  r_idx <= r_idx;
               end
            end
            ST_RUN: begin
               // A capture coinciding with abort is still recorded.
               if (w_cap) begin
                  r_truth[r_idx] <= sop_out;
                  r_mis_cnt      <= w_mis_cnt_nxt;
                  if (w_miss && !r_fail_valid) begin
                     r_fail_valid <= 1'b1;
                     r_first_fail <= r_idx;
                  end else begin
                     r_fail_valid <= r_fail_valid;
                  end
                  if (!w_last) begin
                     r_idx    <= r_idx + IDX_W'(1);
                     r_settle <= 2'd0;
                  end else begin
                     r_idx <= r_idx;
                  end
               end else begin
                  r_settle <= r_settle + 2'd1;
               end

               if (abort || w_last) begin
                  r_vec <= '0;
               end else if (w_cap) begin
                  r_vec <= r_idx + IDX_W'(1);
               end else begin
                  r_vec <= r_idx;
               end

               if (w_last && !abort) begin
                  r_match <= (w_mis_cnt_nxt == '0);
               end else begin
                  r_match <= r_match;
               end
            end
            ST_DONE: r_vec <= '0;
            default: r_vec <= '0;
         endcase
      end
   end

   assign {a, b, c, d, e} = r_vec;
   assign busy            = r_busy;
   assign done            = r_done;
   assign truth           = r_truth;
   assign mismatch_cnt    = r_mis_cnt;
   assign fail_valid      = r_fail_valid;
   assign first_fail      = r_first_fail;
   assign match           = r_match;

endmodule

// File: tb/tb_sop_sweep_capture.sv
// Scoreboard bench: two instances (SETTLE=1 and SETTLE=3) each drive a table-defined SOP model.
module tb_sop_sweep_capture;

   typedef struct {
      logic [31:0] truth;
      logic [5:0]  cnt;
      logic        fv;
      logic [4:0]  ff;
      logic        match;
      longint      start_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  start = 2'b00;
   logic [1:0]  abort = 2'b00;
   logic [1:0]  busy, done, fvl, mat, sop;
   logic [31:0] expd   [2];
   logic [31:0] sop_tt [2];
   logic [31:0] tru    [2];
   logic [5:0]  cnt    [2];
   logic [4:0]  ff     [2];
   logic [4:0]  v0, v1;

   int     n_chk = 0;
   int     n_fail = 0;
   longint cyc = 0;
   int     settle_of [2] = '{1, 3};
   exp_t   q0[$];
   exp_t   q1[$];
   exp_t   mon_e;
   logic [4:0] pv  [2];
   int         run [2];
   logic [1:0] trk = 2'b00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream SOP block: any 5-input function, expressed as its truth table.
   assign sop[0] = sop_tt[0][v0];
   assign sop[1] = sop_tt[1][v1];

   sop_sweep_capture #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
      .expected(expd[0]), .sop_out(sop[0]),
      .a(v0[4]), .b(v0[3]), .c(v0[2]), .d(v0[1]), .e(v0[0]),
      .busy(busy[0]), .done(done[0]), .truth(tru[0]), .mismatch_cnt(cnt[0]),
      .fail_valid(fvl[0]), .first_fail(ff[0]), .match(mat[0])
   );

   sop_sweep_capture #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
      .expected(expd[1]), .sop_out(sop[1]),
      .a(v1[4]), .b(v1[3]), .c(v1[2]), .d(v1[1]), .e(v1[0]),
      .busy(busy[1]), .done(done[1]), .truth(tru[1]), .mismatch_cnt(cnt[1]),
      .fail_valid(fvl[1]), .first_fail(ff[1]), .match(mat[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] vec_of(input int k);
      return (k == 0) ? v0 : v1;
   endfunction

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic void push(input int k, input exp_t e);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   function automatic exp_t pop(input int k);
      if (k == 0) return q0.pop_front();
      else return q1.pop_front();
   endfunction

   function automatic void flush(input int k);
      if (k == 0) q0.delete();
      else q1.delete();
   endfunction

   // Expected result after the first n_cap vectors have been captured.
   function automatic exp_t model(input logic [31:0] tt, input logic [31:0] ex,
                                  input int n_cap, input bit complete);
      exp_t        r;
      logic [31:0] mask;
      logic [31:0] diff;
      mask    = (n_cap >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n_cap) - 32'd1);
      diff    = (tt ^ ex) & mask;
      r.truth = tt & mask;
      r.cnt   = 6'($countones(diff));
      r.fv    = (diff != 32'd0);
      r.ff    = 5'd0;
      for (int i = 31; i >= 0; i--) if (diff[i]) r.ff = 5'(i);
      r.match = complete && (diff == 32'd0);
      r.start_cyc = 0;
      return r;
   endfunction

   task automatic check_result(input int k, input exp_t e);
      check($sformatf("truth[%0d]", k), tru[k], e.truth);
      check($sformatf("mismatch_cnt[%0d]", k), cnt[k], e.cnt);
      check($sformatf("fail_valid[%0d]", k), fvl[k], e.fv);
      if (e.fv) check($sformatf("first_fail[%0d]", k), ff[k], e.ff);
      check($sformatf("match[%0d]", k), mat[k], e.match);
   endtask

   task automatic check_zero(input int k, input string tag);
      check({tag, "_busy"}, busy[k], 1'b0);
      check({tag, "_done"}, done[k], 1'b0);
      check({tag, "_vec"}, vec_of(k), 5'd0);
      check({tag, "_truth"}, tru[k], 32'd0);
      check({tag, "_cnt"}, cnt[k], 6'd0);
      check({tag, "_fv"}, fvl[k], 1'b0);
      check({tag, "_ff"}, ff[k], 5'd0);
      check({tag, "_match"}, mat[k], 1'b0);
   endtask

   // Monitor: scores every done pulse and the per-vector hold length.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (done[k]) begin
            if (qsize(k) == 0) begin
               check("unexpected_done", done[k], 1'b0);
            end else begin
               mon_e = pop(k);
               check_result(k, mon_e);
               check("done_latency", 64'(cyc - mon_e.start_cyc), 64'(32 * settle_of[k]));
               check("busy_in_done", busy[k], 1'b0);
               check("vec_in_done", vec_of(k), 5'd0);
            end
            if (trk[k]) check("hold_last", run[k], settle_of[k]);
            trk[k] = 1'b0;
         end else if (busy[k]) begin
            if (!trk[k]) begin
               check("first_vec", vec_of(k), 5'd0);
               trk[k] = 1'b1;
               pv[k]  = vec_of(k);
               run[k] = 1;
            end else if (vec_of(k) == pv[k]) begin
               run[k]++;
            end else begin
               check("hold_len", run[k], settle_of[k]);
               check("vec_step", vec_of(k), pv[k] + 5'd1);
               pv[k]  = vec_of(k);
               run[k] = 1;
            end
         end else begin
            trk[k] = 1'b0;
         end
      end
   end

   task automatic start_sweep(input int k, input logic [31:0] tt, input logic [31:0] ex,
                              input bit with_abort, input bit track);
      exp_t e;
      @(negedge clk);
      sop_tt[k] = tt;
      expd[k]   = ex;
      start[k]  = 1'b1;
      abort[k]  = with_abort;
      @(posedge clk);
      #1;
      start[k] = 1'b0;
      abort[k] = 1'b0;
      if (track) begin
         e = model(tt, ex, 32, 1'b1);
         e.start_cyc = cyc;
         push(k, e);
      end
   endtask

   task automatic wait_done(input int k);
      int n = 0;
      while (qsize(k) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("sweep_complete", qsize(k), 0);
      flush(k);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_vec(input int k, input logic [4:0] t);
      int n = 0;
      while (!(busy[k] && vec_of(k) == t) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("reach_vec", busy[k] && vec_of(k) == t, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tt;
      logic [31:0] ex;
      exp_t        e;
      expd[0] = 32'd0; expd[1] = 32'd0;
      sop_tt[0] = 32'd0; sop_tt[1] = 32'd0;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero(0, "reset1");
      check_zero(1, "reset3");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_after_reset", busy, 2'b00);

      // AND of all inputs against a matching golden table.
      start_sweep(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      wait_done(0);
      repeat (3) @(negedge clk);
      check("hold_truth", tru[0], 32'h8000_0000);
      check("hold_match", mat[0], 1'b1);
      check("hold_vec", v0, 5'd0);

      // OR of all inputs against an all-zero golden table.
      start_sweep(0, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 1'b1);
      wait_done(0);
      check("or_truth", tru[0], 32'hFFFF_FFFE);
      check("or_cnt", cnt[0], 6'd31);
      check("or_fv", fvl[0], 1'b1);
      check("or_ff", ff[0], 5'd1);
      check("or_match", mat[0], 1'b0);

      start_sweep(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      wait_done(1);

      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 2; k++) begin
            tt = $urandom;
            ex = (i == 3) ? tt : (tt ^ ($urandom & $urandom & $urandom));
            start_sweep(k, tt, ex, 1'b0, 1'b1);
            wait_done(k);
         end
      end

      // start and abort together in IDLE: the sweep must run to completion.
      tt = $urandom;
      start_sweep(0, tt, tt ^ 32'h0001_0100, 1'b1, 1'b1);
      wait_done(0);

      // start re-pulsed mid-sweep with a different golden table is ignored.
      tt = $urandom;
      ex = tt ^ 32'h4000_0020;
      start_sweep(0, tt, ex, 1'b0, 1'b1);
      wait_vec(0, 5'd5);
      start[0] = 1'b1;
      expd[0]  = ~ex;
      @(negedge clk);
      start[0] = 1'b0;
      expd[0]  = ex;
      wait_done(0);

      // abort while vector 10 is held (instance 1 ended its last sweep with match=1).
      check("pre_abort_match", mat[1], 1'b1);
      tt = $urandom;
      ex = tt ^ 32'h0000_8420;
      start_sweep(1, tt, ex, 1'b0, 1'b0);
      wait_vec(1, 5'd10);
      abort[1] = 1'b1;
      @(posedge clk);
      #1;
      abort[1] = 1'b0;
      @(negedge clk);
      check("abort_busy", busy[1], 1'b0);
      check("abort_done", done[1], 1'b0);
      check("abort_vec", v1, 5'd0);
      check_result(1, model(tt, ex, 10, 1'b0));
      repeat (5) @(negedge clk);
      check("abort_stays_idle", busy[1], 1'b0);

      // abort on the same edge as the final capture.
      tt = $urandom;
      ex = tt ^ 32'h8000_0004;
      start_sweep(0, tt, ex, 1'b0, 1'b0);
      wait_vec(0, 5'd31);
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      @(negedge clk);
      check("abort_last_busy", busy[0], 1'b0);
      check("abort_last_done", done[0], 1'b0);
      check_result(0, model(tt, ex, 32, 1'b0));
      repeat (3) @(negedge clk);

      // asynchronous reset in the middle of a sweep.
      tt = $urandom;
      start_sweep(1, tt, tt ^ 32'h0000_0001, 1'b0, 1'b0);
      wait_vec(1, 5'd20);
      rst_n = 1'b0;
      #1;
      check_zero(1, "midreset3");
      check_zero(0, "midreset1");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("no_sweep_after_reset", busy, 2'b00);

      tt = $urandom;
      start_sweep(1, tt, tt ^ 32'h0100_0000, 1'b0, 1'b1);
      wait_done(1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sop_sweep_capture.md
SOP_SWEEP_CAPTURE -- requirements
Module: sop_sweep_capture

Interface
REQ-001 Parameter SETTLE, default 1, number of clock cycles each input vector is held before the response is sampled (legal range 1..4).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  terminates a running sweep.
REQ-006 expected  input  32  golden truth table, bit i = expected out for vector i; latched on start acceptance.
REQ-007 sop_out  input  1  response of the downstream SOP block (its out port).
REQ-008 a, b, c, d, e  output  1 each  registered stimulus to the SOP block; vector index i = {a,b,c,d,e}, a is MSB.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 truth  output  32  captured truth table, bit i = sop_out sampled for vector i.
REQ-012 mismatch_cnt  output  6  number of vectors where sop_out differed from expected (0..32).
REQ-013 fail_valid  output  1  at least one mismatch recorded in the current/last sweep.
REQ-014 first_fail  output  5  index of the lowest-index mismatching vector; meaningful only when fail_valid=1.
REQ-015 match  output  1  high when the last completed sweep had mismatch_cnt=0.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after the capture of vector 31; DONE->IDLE unconditionally after one cycle; RUN->IDLE on abort=1.
REQ-017 On start acceptance: idx=0, settle counter=0, truth, mismatch_cnt, fail_valid, first_fail, match cleared, expected latched; a..e show vector 0 from the next cycle.
REQ-018 In RUN each vector is held on a..e for exactly SETTLE cycles; sop_out is sampled on the last rising edge of that hold into truth[idx].
REQ-019 On the capture edge, if sop_out != expected_latched[idx]: mismatch_cnt+1; if fail_valid=0, first_fail=idx and fail_valid=1.
REQ-020 After capture of idx<31, idx increments and the settle counter restarts at 0 on the same edge; idx never wraps past 31.
REQ-021 Sweep length: 32*SETTLE cycles in RUN; done asserts in the cycle after the final capture, with match=(mismatch_cnt==0) updated on that same edge.
REQ-022 busy=1 exactly while state is RUN; done=1 exactly while state is DONE.
REQ-023 start while RUN or DONE is ignored; start and abort both high in IDLE: start accepted, abort ignored.
REQ-024 abort in RUN: return to IDLE next edge, no done pulse, match stays 0, truth/mismatch_cnt/first_fail retain partial values, a..e driven to 0.
REQ-025 abort and final capture on the same edge: abort wins, capture still written, no done.
REQ-026 In IDLE and DONE, a..e=0; truth, mismatch_cnt, fail_valid, first_fail, match hold their values until the next start.

Reset
REQ-027 rst_n=0 asynchronously forces state IDLE and every output to 0 (a..e, busy, done, truth, mismatch_cnt, fail_valid, first_fail, match), including mid-sweep.
REQ-028 After rst_n deasserts, no sweep begins until start is sampled high.

Structure
REQ-029 Shared package sop_pkg holds the FSM state enum, NUM_VEC=32, IDX_W=5, and CNT_W=6.
REQ-030 Single module, no sub-modules; settle counter is 2 bits, index counter IDX_W bits.

Verification
REQ-031 SETTLE=1, SOP=AND of all inputs, expected=32'h8000_0000, start pulse -> done 33 cycles after start edge, truth=32'h8000_0000, match=1, mismatch_cnt=0.
REQ-032 SETTLE=1, SOP=OR of all inputs, expected=0 -> truth=32'hFFFF_FFFE, mismatch_cnt=31, fail_valid=1, first_fail=1, match=0.
REQ-033 SETTLE=3 -> each a..e vector stable exactly 3 cycles, done 97 cycles after start edge.
REQ-034 abort asserted when idx=10 -> IDLE next cycle, no done, busy=0, a..e=0, truth bits 10..31 = 0.
REQ-035 start pulsed at idx=5 during RUN -> no restart, sweep completes normally; rst_n pulsed low at idx=20 -> all outputs 0 immediately, state IDLE.
